// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding, display digit codes and BCD increment shared by the stopwatch.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_e;
    localparam logic [3:0] DIG_DASH = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hB;
    localparam logic [3:0] DIG_MAX = 4'd9;
    localparam logic [15:0] X_OVF = {4{DIG_DASH}};
    localparam logic [15:0] X_MAX = {4{DIG_MAX}};

    // Ripple-carry increment of four BCD digits; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == DIG_MAX) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/stopwatch_bcd_counter_btn_edge_sync.sv
// btn_edge_sync: two-flop synchroniser plus a third flop giving a one-cycle rising-edge event.
module btn_edge_sync (
    input  logic clk,
    input  logic clr,
    input  logic btn_in,
    output logic evt
);
    logic [2:0] sh_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) sh_q <= '0;
        else sh_q <= {sh_q[1:0], btn_in};
    end

    assign evt = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: SS.cc BCD stopwatch with start/stop, zero and overflow dashes.
// Lap snapshot display is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_ss,
    input  logic        btn_zero,
    input  logic        btn_lap,
    output logic [15:0] x,
    output logic        running,
    output logic        ovf,
    output logic        lap_active
);
    localparam int PW = $clog2(TICK_DIV);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   cnt_q, cnt_d, cnt_inc, x_q, x_d;
    logic          ss_evt, zero_evt, tick, at_max;

    btn_edge_sync u_ss   (.clk(clk), .clr(clr), .btn_in(btn_ss),   .evt(ss_evt));
    btn_edge_sync u_zero (.clk(clk), .clr(clr), .btn_in(btn_zero), .evt(zero_evt));

    assign tick    = (state_q == RUN) && (pre_q == PW'(TICK_DIV - 1));
    assign at_max  = cnt_q == X_MAX;
    assign cnt_inc = bcd_inc(cnt_q);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = ss_evt ? RUN : IDLE;
            RUN: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                // Overflow wins; digits stay at 9999 behind the dash display.
                if (tick && at_max) begin
                    state_d = OVF;
                end else begin
                    cnt_d   = tick ? cnt_inc : cnt_q;
                    state_d = ss_evt ? PAUSE : RUN;
                end
            end
            PAUSE, OVF: begin
                if (zero_evt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                end else if (ss_evt && state_q == PAUSE) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_evt, lap_q, lap_d;
    logic [15:0] snap_q, snap_d;

    btn_edge_sync u_lap (.clk(clk), .clr(clr), .btn_in(btn_lap), .evt(lap_evt));

    // Snapshot takes the post-increment count; the hold drops whenever RUN is left.
    always_comb begin
        lap_d  = lap_q;
        snap_d = snap_q;
        if (state_q == RUN && lap_evt) begin
            lap_d  = ~lap_q;
            snap_d = lap_q ? snap_q : cnt_d;
        end
        if (state_d != RUN) lap_d = 1'b0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lap_q  <= 1'b0;
            snap_q <= '0;
        end else begin
            lap_q  <= lap_d;
            snap_q <= snap_d;
        end
    end

    assign lap_active = lap_q;
    assign x_d        = (state_d == OVF) ? X_OVF : lap_d ? snap_d : cnt_d;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_active = 1'b0;
    assign x_d        = (state_d == OVF) ? X_OVF : cnt_d;
`endif

    assign x       = x_q;
    assign running = state_q == RUN;
    assign ovf     = state_q == OVF;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: directed scoreboard bench for the stopwatch at TICK_DIV = 4.
module tb_stopwatch_bcd_counter;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_zero = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] x;
    logic        running, ovf, lap_active;

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    stopwatch_bcd_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .clr(clr), .btn_ss(btn_ss), .btn_zero(btn_zero), .btn_lap(btn_lap),
        .x(x), .running(running), .ovf(ovf), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    task automatic exp_out(input string tag, input logic [15:0] ex, input logic r, input logic o, input logic l);
        exp_t e;
        e.tag = tag;
        e.v   = {ex, r, o, l};
        q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        assert ({x, running, ovf, lap_active} === e.v) else begin
            n_bad++;
            $error("FAIL %s: got x=%h run=%b ovf=%b lap=%b, want x=%h run=%b ovf=%b lap=%b",
                   e.tag, x, running, ovf, lap_active, e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel: 0 ss, 1 zero, 2 lap, 3 ss+zero; returns just after the action edge.
    task automatic press(input int sel);
        btn_ss   = (sel == 0) || (sel == 3);
        btn_zero = (sel == 1) || (sel == 3);
        btn_lap  = (sel == 2);
        step(2);
        btn_ss   = 1'b0;
        btn_zero = 1'b0;
        btn_lap  = 1'b0;
        step(1);
    endtask

    initial begin
        step(3);
        exp_out("reset", 16'h0000, 0, 0, 0); check();
        clr = 1'b0;
        exp_out("idle50", 16'h0000, 0, 0, 0); step(50); check();

        exp_out("start", 16'h0000, 1, 0, 0); press(0); check();
        exp_out("cnt10", 16'h0010, 1, 0, 0); step(40); check();
        exp_out("cnt100", 16'h0100, 1, 0, 0); step(360); check();
        exp_out("cnt123", 16'h0123, 1, 0, 0); step(92); check();
        exp_out("pause", 16'h0123, 0, 0, 0); press(0); check();
        exp_out("hold", 16'h0123, 0, 0, 0); step(200); check();
        exp_out("resume", 16'h0123, 1, 0, 0); press(0); check();
        exp_out("resume_tick", 16'h0124, 1, 0, 0); step(1); check();

        exp_out("zero_run", 16'h0124, 1, 0, 0); press(1); check();
        exp_out("after_zero_run", 16'h0125, 1, 0, 0); step(1); check();
        exp_out("pause2", 16'h0125, 0, 0, 0); press(0); check();
        exp_out("zero_pause", 16'h0000, 0, 0, 0); press(1); check();

        press(0);
        exp_out("run2", 16'h0002, 1, 0, 0); step(8); check();
        exp_out("pause3", 16'h0002, 0, 0, 0); press(0); check();
        exp_out("ss_zero_pause", 16'h0000, 0, 0, 0); press(3); check();
        exp_out("idle_stays", 16'h0000, 0, 0, 0); step(8); check();

        press(0);
        step(8);
        exp_out("ss_zero_run", 16'h0002, 0, 0, 0); press(3); check();
        exp_out("zero_after", 16'h0000, 0, 0, 0); press(1); check();

        press(0);
        exp_out("max", 16'h9999, 1, 0, 0); step(9999 * TD); check();
        exp_out("ovf", 16'hAAAA, 0, 1, 0); step(TD); check();
        exp_out("ovf_ss", 16'hAAAA, 0, 1, 0); press(0); check();
        exp_out("ovf_lap", 16'hAAAA, 0, 1, 0); press(2); check();
        exp_out("ovf_zero", 16'h0000, 0, 0, 0); press(1); check();

`ifdef STOPWATCH_LAP_EN
        press(0);
        exp_out("lap_pre", 16'h0057, 1, 0, 0); step(57 * TD); check();
        exp_out("lap_set", 16'h0057, 1, 0, 1); press(2); check();
        exp_out("lap_frozen", 16'h0057, 1, 0, 1); step(1); check();
        exp_out("lap_hold", 16'h0057, 1, 0, 1); step(7 * TD); check();
        exp_out("lap_release", 16'h0065, 1, 0, 0); press(2); check();
`else
        press(0);
        exp_out("lap_ignored", 16'h0000, 1, 0, 0); press(2); check();
        exp_out("lap_live", 16'h0001, 1, 0, 0); step(1); check();
`endif

        step(2);
        #2;
        clr = 1'b1;
        #1;
        exp_out("clr_async", 16'h0000, 0, 0, 0); check();
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_out("after_clr", 16'h0000, 0, 0, 0); step(5); check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
